// File: rtl/mcb_arb_pkg.sv
// Shared definitions for the MCB command-port arbiter.
// Holds MCB instruction codes, the arbiter state encoding and field widths.
// Pure declarations; no logic state lives here.
package mcb_arb_pkg;

  localparam int ADDR_W  = 30;
  localparam int BL_W    = 6;
  localparam int INSTR_W = 3;

  localparam logic [INSTR_W-1:0] MCB_WR    = 3'b000;
  localparam logic [INSTR_W-1:0] MCB_RD    = 3'b001;
  localparam logic [INSTR_W-1:0] MCB_WR_AP = 3'b010;
  localparam logic [INSTR_W-1:0] MCB_RD_AP = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // Only plain and auto-precharge reads/writes may reach the MCB
  function automatic logic is_legal_instr(input logic [INSTR_W-1:0] instr);
    return (instr == MCB_WR) || (instr == MCB_RD) ||
           (instr == MCB_WR_AP) || (instr == MCB_RD_AP);
  endfunction

  // Reads only need the command FIFO to drain; writes also need write data gone
  function automatic logic is_read_instr(input logic [INSTR_W-1:0] instr);
    return (instr == MCB_RD) || (instr == MCB_RD_AP);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way requester pick: round-robin on ties, or strict priority for requester 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arb2
  import mcb_arb_pkg::*;
#(
  parameter bit WR_PRIORITY = 1'b0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       win_valid,
  output logic       win_id
);

  // A tie under round-robin goes to whoever did not finish last; otherwise requester 0 first
  always_comb begin
    win_valid = |req;
    if (!WR_PRIORITY && (&req)) begin
      win_id = ~last_grant;
    end else begin
      win_id = ~req[0];
    end
  end

endmodule

// File: rtl/mcb_port_arbiter.sv
// Shares one MCB command port between the pattern writer (0) and reader (1), one burst at a time.
// Latency: request sampled in IDLE -> cmd_en/ack one cycle later; at least 4 cycles per command.
// Backpressure: cmd_full stalls in ISSUE; the port stays owned until the burst drains or times out.
module mcb_port_arbiter
  import mcb_arb_pkg::*;
#(
  parameter int WR_PRIORITY = 0,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              mem_clk,
  input  logic              fsm_rst,
  input  logic [1:0]        req_valid,
  input  logic [2:0]        req0_instr,
  input  logic [2:0]        req1_instr,
  input  logic [29:0]       req0_addr,
  input  logic [29:0]       req1_addr,
  input  logic [5:0]        req0_bl,
  input  logic [5:0]        req1_bl,
  output logic [1:0]        req_ack,
  output logic [1:0]        req_done,
  output logic              cmd_en,
  output logic [2:0]        cmd_instr,
  output logic [5:0]        cmd_bl,
  output logic [29:0]       cmd_byte_addr,
  input  logic              cmd_full,
  input  logic              cmd_empty,
  input  logic              wr_empty,
  output logic              busy,
  output logic              grant_id,
  output logic              err_align,
  output logic              err_instr,
  output logic              err_timeout
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_t          state;
  logic                last_grant;
  logic [INSTR_W-1:0]  instr_q;
  logic [ADDR_W-1:3]   addr_q;
  logic [BL_W-1:0]     bl_q;
  logic [CNT_W-1:0]    wait_cnt;

  logic                win_valid;
  logic                win_id;
  logic [INSTR_W-1:0]  win_instr;
  logic [ADDR_W-1:0]   win_addr;
  logic [BL_W-1:0]     win_bl;
  logic                drained;

  rr_arb2 #(
    .WR_PRIORITY (WR_PRIORITY != 0)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .win_valid  (win_valid),
    .win_id     (win_id)
  );

  // Steer the winning requester's command fields toward the capture registers
  always_comb begin
    win_instr = req0_instr;
    win_addr  = req0_addr;
    win_bl    = req0_bl;
    if (win_id) begin
      win_instr = req1_instr;
      win_addr  = req1_addr;
      win_bl    = req1_bl;
    end
  end

  // A write is only complete once its data has left the write FIFO as well
  assign drained = cmd_empty && (is_read_instr(instr_q) || wr_empty);

  assign busy          = (state != IDLE);
  assign cmd_instr     = instr_q;
  assign cmd_bl        = bl_q;
  assign cmd_byte_addr = {addr_q, 3'b000};

  // Arbitration FSM: capture in IDLE, push in ISSUE, hold the port in WAIT until drained
  always_ff @(posedge mem_clk or posedge fsm_rst) begin
    if (fsm_rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant_id    <= 1'b0;
      instr_q     <= '0;
      addr_q      <= '0;
      bl_q        <= '0;
      wait_cnt    <= '0;
      req_ack     <= '0;
      req_done    <= '0;
      cmd_en      <= 1'b0;
      err_align   <= 1'b0;
      err_instr   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      req_ack  <= '0;
      req_done <= '0;
      cmd_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            grant_id <= win_id;
            instr_q  <= win_instr;
            addr_q   <= win_addr[ADDR_W-1:3];
            bl_q     <= win_bl;
            // Misaligned addresses are still issued, rounded down to the 8-byte boundary
            if (win_addr[2:0] != 3'b000) begin
              err_align <= 1'b1;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!is_legal_instr(instr_q)) begin
            err_instr          <= 1'b1;
            req_ack[grant_id]  <= 1'b1;
            req_done[grant_id] <= 1'b1;
            state              <= IDLE;
          end else if (!cmd_full) begin
            cmd_en            <= 1'b1;
            req_ack[grant_id] <= 1'b1;
            wait_cnt          <= '0;
            state             <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // First WAIT cycle is skipped: the MCB empty flags lag the cmd_en push
          if ((wait_cnt != '0) && drained) begin
            req_done[grant_id] <= 1'b1;
            last_grant         <= grant_id;
            state              <= IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            err_timeout        <= 1'b1;
            req_done[grant_id] <= 1'b1;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcb_port_arbiter.sv
// Bench for mcb_port_arbiter: a round-robin and a write-priority instance share stimulus.
// A transaction-rule model predicts every output of both instances every cycle.
// Table vectors, hand sequences for stalls/timeouts/reset, then random traffic.
module tb_mcb_port_arbiter;
  import mcb_arb_pkg::*;

  localparam int TO = 16;

  logic        mem_clk = 1'b0;
  logic        fsm_rst;
  logic [1:0]  req_valid;
  logic [2:0]  req0_instr, req1_instr;
  logic [29:0] req0_addr, req1_addr;
  logic [5:0]  req0_bl, req1_bl;
  logic        cmd_full, cmd_empty, wr_empty;

  logic [1:0]  ack [2];
  logic [1:0]  done [2];
  logic        en [2];
  logic [2:0]  c_instr [2];
  logic [5:0]  c_bl [2];
  logic [29:0] c_addr [2];
  logic        bsy [2], gnt [2], e_al [2], e_in [2], e_to [2];

  mcb_port_arbiter #(.WR_PRIORITY(0), .TIMEOUT_CYC(TO)) dut (
    .mem_clk(mem_clk), .fsm_rst(fsm_rst), .req_valid(req_valid),
    .req0_instr(req0_instr), .req1_instr(req1_instr), .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_bl(req0_bl), .req1_bl(req1_bl), .req_ack(ack[0]), .req_done(done[0]),
    .cmd_en(en[0]), .cmd_instr(c_instr[0]), .cmd_bl(c_bl[0]), .cmd_byte_addr(c_addr[0]),
    .cmd_full(cmd_full), .cmd_empty(cmd_empty), .wr_empty(wr_empty), .busy(bsy[0]),
    .grant_id(gnt[0]), .err_align(e_al[0]), .err_instr(e_in[0]), .err_timeout(e_to[0]));

  mcb_port_arbiter #(.WR_PRIORITY(1), .TIMEOUT_CYC(TO)) dut_p (
    .mem_clk(mem_clk), .fsm_rst(fsm_rst), .req_valid(req_valid),
    .req0_instr(req0_instr), .req1_instr(req1_instr), .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_bl(req0_bl), .req1_bl(req1_bl), .req_ack(ack[1]), .req_done(done[1]),
    .cmd_en(en[1]), .cmd_instr(c_instr[1]), .cmd_bl(c_bl[1]), .cmd_byte_addr(c_addr[1]),
    .cmd_full(cmd_full), .cmd_empty(cmd_empty), .wr_empty(wr_empty), .busy(bsy[1]),
    .grant_id(gnt[1]), .err_align(e_al[1]), .err_instr(e_in[1]), .err_timeout(e_to[1]));

  always #5 mem_clk = ~mem_clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: owner (-1 = port free), whether the command went out, WAIT cycles elapsed
  int          m_own [2];
  bit          m_issued [2];
  int          m_wcnt [2];
  bit          m_last [2], m_gnt [2], m_al [2], m_ei [2], m_et [2], m_en [2];
  logic [2:0]  m_instr [2];
  logic [29:0] m_addr [2];
  logic [5:0]  m_bl [2];
  logic [1:0]  m_ack [2], m_done [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_own[d] = -1; m_issued[d] = 0; m_wcnt[d] = 0; m_last[d] = 1; m_gnt[d] = 0;
      m_al[d] = 0; m_ei[d] = 0; m_et[d] = 0; m_en[d] = 0;
      m_instr[d] = '0; m_addr[d] = '0; m_bl[d] = '0; m_ack[d] = '0; m_done[d] = '0;
    end
  endtask

  task automatic model_step();
    if (fsm_rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      int w;
      logic [29:0] a;
      m_ack[d] = '0; m_done[d] = '0; m_en[d] = 0;
      if (m_own[d] < 0) begin
        if (req_valid != 2'b00) begin
          // d=0 alternates on ties; d=1 always favours requester 0
          if (d == 0 && req_valid == 2'b11) w = m_last[d] ? 0 : 1;
          else w = req_valid[0] ? 0 : 1;
          m_own[d] = w; m_issued[d] = 0; m_gnt[d] = (w == 1);
          a = (w == 1) ? req1_addr : req0_addr;
          m_instr[d] = (w == 1) ? req1_instr : req0_instr;
          m_bl[d] = (w == 1) ? req1_bl : req0_bl;
          m_addr[d] = a - (a % 8);
          if (a % 8 != 0) m_al[d] = 1;
        end
      end else if (!m_issued[d]) begin
        if (m_instr[d] > 3) begin
          m_ei[d] = 1; m_ack[d][m_own[d]] = 1'b1; m_done[d][m_own[d]] = 1'b1; m_own[d] = -1;
        end else if (!cmd_full) begin
          m_en[d] = 1; m_ack[d][m_own[d]] = 1'b1; m_issued[d] = 1; m_wcnt[d] = 0;
        end
      end else begin
        m_wcnt[d]++;
        if (m_wcnt[d] > 1 && cmd_empty && (m_instr[d] % 2 == 1 || wr_empty)) begin
          m_done[d][m_own[d]] = 1'b1; m_last[d] = (m_own[d] == 1); m_own[d] = -1;
        end else if (m_wcnt[d] == TO) begin
          m_et[d] = 1; m_done[d][m_own[d]] = 1'b1; m_own[d] = -1;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("cycle%0d dut%0d outputs", cyc, d),
            {ack[d], done[d], en[d], bsy[d], gnt[d], e_al[d], e_in[d], e_to[d], c_instr[d], c_bl[d], c_addr[d]},
            {m_ack[d], m_done[d], m_en[d], m_own[d] >= 0, m_gnt[d], m_al[d], m_ei[d], m_et[d],
             m_instr[d], m_bl[d], m_addr[d]});
    end
  endtask

  task automatic step();
    @(posedge mem_clk);
    model_step();
    @(negedge mem_clk);
    cyc++;
    compare_all();
  endtask

  task automatic do_reset();
    fsm_rst = 1'b1;
    req_valid = 2'b00;
    req0_instr = '0; req1_instr = '0; req0_addr = '0; req1_addr = '0; req0_bl = '0; req1_bl = '0;
    cmd_full = 1'b0; cmd_empty = 1'b1; wr_empty = 1'b1;
    model_reset();
    #1;
    check("reset outputs zero",
          {ack[0], done[0], en[0], bsy[0], gnt[0], e_al[0], e_in[0], e_to[0], c_instr[0], c_bl[0], c_addr[0]}, 0);
    compare_all();
    step();
    step();
    fsm_rst = 1'b0;
  endtask

  task automatic set_req(input int id, input logic [2:0] ins, input logic [29:0] a, input logic [5:0] b);
    if (id == 0) begin
      req0_instr = ins; req0_addr = a; req0_bl = b;
    end else begin
      req1_instr = ins; req1_addr = a; req1_bl = b;
    end
    req_valid[id] = 1'b1;
  endtask

  task automatic new_fields(input int id);
    logic [2:0] ins;
    ins = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
    set_req(id, ins, 30'($urandom), 6'($urandom));
  endtask

  typedef struct {
    int          id;
    logic [2:0]  ins;
    logic [29:0] addr;
    logic [5:0]  bl;
    logic [29:0] exp_addr;
    bit          exp_al;
    bit          exp_bad;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nrr, np, p1;
    tbl[0] = '{0, MCB_WR,    30'h100,        6'd31, 30'h100,        0, 0};
    tbl[1] = '{1, MCB_RD,    30'h2000_0040,  6'd7,  30'h2000_0040,  0, 0};
    tbl[2] = '{0, MCB_WR_AP, 30'h105,        6'd0,  30'h100,        1, 0};
    tbl[3] = '{1, 3'b100,    30'h80,         6'd3,  30'h80,         0, 1};
    tbl[4] = '{1, MCB_RD_AP, 30'h3FFF_FFFF,  6'd63, 30'h3FFF_FFF8,  1, 0};

    fsm_rst = 1'b0;
    #1;
    do_reset();

    // Single-command vectors: capture, issue, guard, drain
    for (int i = 0; i < 5; i++) begin
      do_reset();
      set_req(tbl[i].id, tbl[i].ins, tbl[i].addr, tbl[i].bl);
      step();
      check($sformatf("tbl%0d busy after capture", i), bsy[0], 1);
      check($sformatf("tbl%0d no early cmd_en", i), en[0], 0);
      step();
      check($sformatf("tbl%0d ack", i), ack[0], 2'b01 << tbl[i].id);
      check($sformatf("tbl%0d cmd_en", i), en[0], !tbl[i].exp_bad);
      check($sformatf("tbl%0d addr", i), c_addr[0], tbl[i].exp_addr);
      check($sformatf("tbl%0d bl", i), c_bl[0], tbl[i].bl);
      check($sformatf("tbl%0d err_align", i), e_al[0], tbl[i].exp_al);
      check($sformatf("tbl%0d err_instr", i), e_in[0], tbl[i].exp_bad);
      check($sformatf("tbl%0d done with ack", i), done[0], tbl[i].exp_bad ? (2'b01 << tbl[i].id) : 2'b00);
      req_valid = 2'b00;
      if (!tbl[i].exp_bad) begin
        step();
        check($sformatf("tbl%0d guard no done", i), done[0], 0);
        step();
        check($sformatf("tbl%0d done", i), done[0], 2'b01 << tbl[i].id);
      end
      check($sformatf("tbl%0d idle after", i), bsy[0], 0);
    end

    // Write waits for both empties; read ignores wr_empty
    do_reset();
    wr_empty = 1'b0;
    set_req(0, MCB_WR, 30'h40, 6'd3);
    step(); step();
    req_valid = 2'b00;
    for (int k = 0; k < 5; k++) begin
      step();
      check("write held by wr_empty", done[0], 0);
    end
    cmd_empty = 1'b0; wr_empty = 1'b1;
    step();
    check("write held by cmd_empty", done[0], 0);
    cmd_empty = 1'b1;
    step();
    check("write done", done[0], 2'b01);
    wr_empty = 1'b0;
    set_req(1, MCB_RD, 30'h48, 6'd1);
    step(); step();
    req_valid = 2'b00;
    step(); step();
    check("read ignores wr_empty", done[0], 2'b10);
    wr_empty = 1'b1;

    // cmd_full stalls ISSUE for 10 cycles
    do_reset();
    cmd_full = 1'b1;
    set_req(1, MCB_RD_AP, 30'h88, 6'd15);
    step();
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (ack[0] != 0 || en[0]) n++;
    end
    check("stall no ack or cmd_en", n, 0);
    cmd_full = 1'b0;
    step();
    check("stall release ack", ack[0], 2'b10);
    check("stall release cmd_en", en[0], 1);
    req_valid = 2'b00;
    step();
    check("cmd_en single cycle", en[0], 0);

    // Timeout with wr_empty stuck low
    do_reset();
    wr_empty = 1'b0;
    set_req(0, MCB_WR, 30'h200, 6'd7);
    step(); step();
    req_valid = 2'b00;
    check("timeout ack", ack[0], 2'b01);
    n = 0;
    while (done[0] == 2'b00 && n < 100) begin
      step();
      n++;
    end
    check("timeout WAIT cycles", n, TO);
    check("timeout done id", done[0], 2'b01);
    check("err_timeout", e_to[0], 1);
    check("timeout idle", bsy[0], 0);

    // Reset in WAIT clears everything; next tie goes to requester 0
    do_reset();
    wr_empty = 1'b0;
    set_req(1, MCB_WR, 30'h107, 6'd2);
    step(); step();
    req_valid = 2'b00;
    step(); step();
    check("pre-reset busy", bsy[0], 1);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step();
      check("no done after reset", done[0], 0);
    end
    req_valid = 2'b11;
    step(); step();
    check("first tie after reset", ack[0], 2'b01);
    req_valid = 2'b00;
    step(); step();

    // Both requesters always pending: alternation vs strict priority
    do_reset();
    set_req(0, MCB_RD, 30'h1000, 6'd5);
    set_req(1, MCB_RD, 30'h2000, 6'd9);
    nrr = 0; np = 0; p1 = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (ack[0] != 2'b00) begin
        check($sformatf("rr grant %0d", nrr), ack[0], (nrr % 2 == 0) ? 2'b01 : 2'b10);
        nrr++;
      end
      if (ack[1][0]) np++;
      if (ack[1][1] || done[1][1]) p1++;
    end
    check("rr grant count", nrr, 10);
    check("prio grant count", np, 10);
    check("prio requester 1 activity", p1, 0);
    req_valid = 2'b00;

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (ack[0][r]) begin
          if ($urandom_range(0, 3) != 0) req_valid[r] = 1'b0;
          else new_fields(r);
        end else if (!req_valid[r] && $urandom_range(0, 3) == 0) begin
          new_fields(r);
        end
      end
      cmd_full  = ($urandom_range(0, 3) == 0);
      cmd_empty = ($urandom_range(0, 3) != 0);
      wr_empty  = (c % 800 >= 600) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 599) == 0) do_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
